// File: rtl/led_mux_pkg.sv
// Shared types and helpers for the LED source arbiter and future arbiters.
package led_mux_pkg;

  typedef enum logic {NORMAL, ALERT} led_mux_state_t;

  localparam int unsigned LedW = 8;

  // Index of the lowest set bit; 0 when nothing is set (callers gate with |vec).
  function automatic logic [3:0] lowest_set(input logic [15:0] vec);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (vec[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter and a 1-cycle
// pulse on each accepted press. Releases produce no pulse.
module btn_debounce
  import led_mux_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 250000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int unsigned CntW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic            sync1_q, sync2_q;
  logic            level_q, level_d, level_prev_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= i_btn;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q        <= cnt_d;
    end
  end

  // Any agreement between synced and debounced levels restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYC - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  assign o_pulse = level_q & ~level_prev_q;

endmodule

// File: rtl/led_mux_ctrl.sv
// Arbitrates the 8 user LEDs between N_SRC status sources with button selection
// and preempting alerts. Define LED_MUX_BLINK_EN to blink the alert display.
module led_mux_ctrl
  import led_mux_pkg::*;
#(
  parameter int unsigned N_SRC          = 4,
  parameter int unsigned DEBOUNCE_CYC   = 250000,
  parameter int unsigned ALERT_HOLD_CYC = 12500000,
  parameter int unsigned BLINK_CYC      = 3125000
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_btn_next,
  input  logic [N_SRC*8-1:0]         i_src_data,
  input  logic [N_SRC-1:0]           i_alert_req,
  output logic [LedW-1:0]            o_led,
  output logic [$clog2(N_SRC)-1:0]   o_sel,
  output logic                       o_alert_active,
  output logic [$clog2(N_SRC)-1:0]   o_alert_id
);

  localparam int unsigned SelW  = $clog2(N_SRC);
  localparam int unsigned HoldW = $clog2(ALERT_HOLD_CYC);

  if (N_SRC < 2 || N_SRC > 16) begin : g_bad_n_src
    $error("led_mux_ctrl: N_SRC must be 2..16");
  end
  if (DEBOUNCE_CYC < 2) begin : g_bad_debounce
    $error("led_mux_ctrl: DEBOUNCE_CYC must be >= 2");
  end
  if (ALERT_HOLD_CYC < 2) begin : g_bad_hold
    $error("led_mux_ctrl: ALERT_HOLD_CYC must be >= 2");
  end
  if (BLINK_CYC < 1) begin : g_bad_blink
    $error("led_mux_ctrl: BLINK_CYC must be >= 1");
  end

  logic                 next_pulse;
  logic [LedW-1:0]      src_arr [N_SRC];
  led_mux_state_t       state_q, state_d;
  logic [SelW-1:0]      sel_q, sel_d;
  logic [SelW-1:0]      id_q, id_d;
  logic [SelW-1:0]      req_low;
  logic                 req_any;
  logic                 load;
  logic [HoldW-1:0]     hold_q, hold_d;
  logic [LedW-1:0]      led_q, led_d;
  logic                 show;

  btn_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_btn_debounce (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_btn   (i_btn_next),
    .o_pulse (next_pulse)
  );

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    assign src_arr[g] = i_src_data[8*g +: 8];
  end

  assign req_any = |i_alert_req;
  assign req_low = SelW'(lowest_set(16'(i_alert_req)));

  // Selection keeps advancing during an alert; it only becomes visible on return.
  always_comb begin
    sel_d = sel_q;
    if (next_pulse) begin
      sel_d = (sel_q == SelW'(N_SRC - 1)) ? '0 : sel_q + SelW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    hold_d  = (hold_q != '0) ? hold_q - HoldW'(1) : '0;
    load    = 1'b0;
    case (state_q)
      NORMAL: begin
        if (req_any) load = 1'b1;
      end
      ALERT: begin
        if (req_any && (req_low < id_q)) begin
          load = 1'b1;
        end else if ((hold_q == '0) && !i_alert_req[id_q]) begin
          // The shown request is gone here, so any remaining bit is another source.
          if (req_any) load = 1'b1;
          else         state_d = NORMAL;
        end
      end
      default: state_d = NORMAL;
    endcase
    if (load) begin
      state_d = ALERT;
      id_d    = req_low;
      hold_d  = HoldW'(ALERT_HOLD_CYC - 1);
    end
  end

`ifdef LED_MUX_BLINK_EN
  localparam int unsigned BlinkW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              phase_q, phase_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  // Every entry or reload restarts the blink lit, so a new alert is seen at once.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (load) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (state_q == ALERT) begin
      if (blink_cnt_q == BlinkW'(BLINK_CYC - 1)) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BlinkW'(1);
      end
    end
  end

  assign show = phase_d;
`else
  assign show = 1'b1;
`endif

  always_comb begin
    led_d = src_arr[sel_d];
    if (state_d == ALERT) begin
      led_d = show ? src_arr[id_d] : '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= NORMAL;
      sel_q   <= '0;
      id_q    <= '0;
      hold_q  <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      id_q    <= id_d;
      hold_q  <= hold_d;
      led_q   <= led_d;
    end
  end

  assign o_led          = led_q;
  assign o_sel          = sel_q;
  assign o_alert_active = (state_q == ALERT);
  assign o_alert_id     = id_q;

endmodule

// File: tb/tb_led_mux_ctrl.sv
// Self-checking bench for led_mux_ctrl: directed scenarios plus random stimulus
// against a cycle-level behavioural model built from window/deadline rules.
module tb_led_mux_ctrl;

  localparam int NSrc  = 4;
  localparam int Deb   = 4;
  localparam int Hold  = 16;
  localparam int Blink = 4;
  localparam logic [31:0] SrcDefault = 32'hD3C2B1A0;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        btn   = 1'b0;
  logic [31:0] src   = SrcDefault;
  logic [3:0]  req   = 4'b0000;
  logic [7:0]  led;
  logic [1:0]  sel;
  logic        alert_active;
  logic [1:0]  alert_id;

  int n_checks = 0;
  int n_pass   = 0;

  led_mux_ctrl #(
    .N_SRC          (NSrc),
    .DEBOUNCE_CYC   (Deb),
    .ALERT_HOLD_CYC (Hold),
    .BLINK_CYC      (Blink)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_btn_next     (btn),
    .i_src_data     (src),
    .i_alert_req    (req),
    .o_led          (led),
    .o_sel          (sel),
    .o_alert_active (alert_active),
    .o_alert_id     (alert_id)
  );

  always #5 clk = ~clk;

  // Model state: edge count, alert deadline (edge at which hold reaches 0),
  // button sample histories and a pending selection advance.
  int         cyc;
  bit         m_alert;
  int         m_id, m_exp, m_load, m_sel;
  bit         m_deb, m_pend;
  bit         bh[$];
  bit         sh[$];
  logic [7:0] m_led;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int lowest(input logic [3:0] r);
    for (int i = 0; i < 4; i++) if (r[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] src_byte(input logic [31:0] s, input int k);
    return s[8*k +: 8];
  endfunction

  task automatic model_reset();
    cyc = 0; m_alert = 0; m_id = 0; m_exp = 0; m_load = 0; m_sel = 0;
    m_deb = 0; m_pend = 0; m_led = 8'h00;
    bh.delete();
    sh.delete();
  endtask

  task automatic model_load(input int idx);
    m_alert = 1; m_id = idx; m_exp = cyc + Hold - 1; m_load = cyc;
  endtask

  task automatic model_step();
    bit s2, flip, adv;
    int lo;
    cyc++;
    // Synchronized level seen at this edge is the button sampled two edges ago.
    bh.push_back(btn);
    if (bh.size() > 8) void'(bh.pop_front());
    s2 = (bh.size() >= 3) ? bh[bh.size()-3] : 1'b0;
    sh.push_back(s2);
    if (sh.size() > 8) void'(sh.pop_front());
    adv = m_pend;
    m_pend = 0;
    if (sh.size() >= Deb) begin
      flip = 1;
      for (int k = 1; k <= Deb; k++) if (sh[sh.size()-k] == m_deb) flip = 0;
      if (flip) begin
        m_deb  = ~m_deb;
        m_pend = m_deb;
      end
    end
    if (adv) m_sel = (m_sel + 1) % NSrc;
    lo = lowest(req);
    if (!m_alert) begin
      if (lo >= 0) model_load(lo);
    end else if (lo >= 0 && lo < m_id) begin
      model_load(lo);
    end else if (cyc > m_exp && !req[m_id]) begin
      if (lo >= 0) model_load(lo);
      else m_alert = 0;
    end
    if (m_alert) begin
`ifdef LED_MUX_BLINK_EN
      m_led = (((cyc - m_load) / Blink) % 2 == 0) ? src_byte(src, m_id) : 8'h00;
`else
      m_led = src_byte(src, m_id);
`endif
    end else begin
      m_led = src_byte(src, m_sel);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_val("led", led, m_led);
    check_val("sel", sel, m_sel);
    check_val("alert_active", alert_active, m_alert);
    check_val("alert_id", alert_id, m_id);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic press(input int hi, input int lo);
    btn = 1'b1;
    ticks(hi);
    btn = 1'b0;
    ticks(lo);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rst_led", led, 32'h0);
    check_val("rst_sel", sel, 32'h0);
    check_val("rst_alert_active", alert_active, 32'h0);
    check_val("rst_alert_id", alert_id, 32'h0);
    model_reset();
    btn = 1'b0;
    req = 4'b0000;
    src = SrcDefault;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_val("led_after_rst", led, 32'hA0);
  endtask

  initial begin
    int cnt;
    int run;
    int b;
    logic [7:0] exp_led;

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_val("init_led", led, 32'h0);
    check_val("init_sel", sel, 32'h0);
    check_val("init_alert_active", alert_active, 32'h0);
    check_val("init_alert_id", alert_id, 32'h0);
    model_reset();
    rst_n = 1'b1;
    tick();
    check_val("init_led_after_rst", led, 32'hA0);

    // Clean presses cycle the selection and wrap.
    for (int i = 0; i < 4; i++) begin
      press(10, 10);
      check_val("press_sel", sel, 32'((i + 1) % 4));
    end
    press(3, 10);
    check_val("glitch_sel", sel, 32'h0);

    // Single-cycle alert pulse holds the display for the full minimum time.
    req = 4'b0100;
    tick();
    req = 4'b0000;
    cnt = alert_active ? 1 : 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (alert_active) cnt++;
    end
    check_val("alert_len", cnt, 32'd16);
    check_val("alert_back_led", led, 32'hA0);

    // Preemption by a lower index, then chaining back to the held request.
    req = 4'b1000;
    ticks(11);
    req = 4'b1010;
    tick();
    check_val("preempt_id", alert_id, 32'd1);
    req = 4'b1000;
    ticks(15);
    check_val("preempt_hold_id", alert_id, 32'd1);
    tick();
    check_val("chain_id", alert_id, 32'd3);
    ticks(20);
    check_val("chain_held_id", alert_id, 32'd3);
    req = 4'b0000;
    ticks(20);
    check_val("chain_done", alert_active, 32'd0);

    // Button during an alert: selection moves, display stays on the alert.
    req = 4'b0100;
    btn = 1'b1;
    ticks(10);
    check_val("btn_in_alert_led", led, 32'hC2);
    req = 4'b0000;
    btn = 1'b0;
    ticks(25);
    check_val("btn_in_alert_sel", sel, 32'd1);
    check_val("btn_in_alert_led_after", led, 32'hB1);

    // Alert on source 0: blink pattern when enabled, steady otherwise.
    press(10, 10);
    press(10, 10);
    press(10, 10);
    req = 4'b0001;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (k == 0) req = 4'b0000;
`ifdef LED_MUX_BLINK_EN
      exp_led = ((k / Blink) % 2 == 0) ? 8'hA0 : 8'h00;
`else
      exp_led = 8'hA0;
`endif
      check_val("alert0_led", led, 32'(exp_led));
    end
    ticks(20);

    // Random phase with periodic asynchronous resets.
    run = 0;
    for (int i = 0; i < 2000; i++) begin
      if (run == 0) begin
        btn = ~btn;
        run = int'($urandom_range(1, 12));
      end
      run--;
      if ($urandom_range(0, 15) == 0) begin
        b = int'($urandom_range(0, 3));
        req[b] = ~req[b];
      end
      if ($urandom_range(0, 63) == 0) src = $urandom();
      if (i % 500 == 499) async_reset();
      else tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
